// File: rtl/vsram_read_seq.sv
// Burst reader for a dual-read-port SRAM: fetches two words per cycle and
// streams them in ascending address order through a 4-entry FIFO.
module vsram_read_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  base_addr,
  input  logic [9:0]  length,
  output logic [8:0]  rd_addr1,
  output logic [8:0]  rd_addr2,
  input  logic [47:0] rd_data1,
  input  logic [47:0] rd_data2,
  output logic [47:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [8:0]  ptr_q, ptr_d;
  logic [9:0]  rem_q, rem_d;
  logic [8:0]  a1_q, a1_d, a2_q, a2_d;
  logic [1:0]  infl_q, infl_d;
  logic        done_q, done_d;

  logic [47:0] mem_q [4];
  logic [1:0]  wp_q, rp_q;
  logic [2:0]  cnt_q;

  logic        rd_fire;
  logic [3:0]  free_w;
  logic        fetch_ok;
  logic [1:0]  nfetch;

  assign rd_fire  = (cnt_q != 3'd0) && out_ready;
  // A pop at this edge frees a slot before the fetched data lands next edge,
  // which is what keeps the stream at one word per cycle with only 4 entries.
  assign free_w   = 4'd4 - {1'b0, cnt_q} + {3'b0, rd_fire};
  assign fetch_ok = free_w >= ({2'b0, infl_q} + 4'd2);
  assign nfetch   = (rem_q >= 10'd2) ? 2'd2 : rem_q[1:0];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    infl_d  = 2'd0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == 10'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = ISSUE;
            ptr_d   = base_addr;
            rem_d   = length;
          end
        end
      end
      ISSUE: begin
        if (rem_q != 10'd0 && fetch_ok) begin
          a1_d   = ptr_q;
          a2_d   = ptr_q + 9'd1;
          ptr_d  = ptr_q + 9'd2;
          rem_d  = rem_q - {8'b0, nfetch};
          infl_d = nfetch;
          if (rem_q <= 10'd2) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (infl_q == 2'd0 &&
            (cnt_q == 3'd0 || (cnt_q == 3'd1 && rd_fire))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 9'd0;
      rem_q   <= 10'd0;
      a1_q    <= 9'd0;
      a2_q    <= 9'd0;
      infl_q  <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      infl_q  <= infl_d;
      done_q  <= done_d;
    end
  end

  // infl_q words of last edge's fetch are on rd_data now; port 1 goes first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 48'd0;
      wp_q  <= 2'd0;
      rp_q  <= 2'd0;
      cnt_q <= 3'd0;
    end else begin
      if (infl_q != 2'd0) mem_q[wp_q] <= rd_data1;
      if (infl_q == 2'd2) mem_q[wp_q + 2'd1] <= rd_data2;
      wp_q  <= wp_q + infl_q;
      rp_q  <= rp_q + {1'b0, rd_fire};
      cnt_q <= cnt_q + {1'b0, infl_q} - {2'b0, rd_fire};
    end
  end

  assign rd_addr1  = a1_q;
  assign rd_addr2  = a2_q;
  assign out_data  = mem_q[rp_q];
  assign out_valid = cnt_q != 3'd0;
  assign busy      = state_q != IDLE;
  assign done      = done_q;

endmodule

// File: tb/tb_vsram_read_seq.sv
// Randomized bench: SRAM contents are random, expected stream is the word
// sequence at (base + i) mod 512, compared against what the consumer accepts.
module tb_vsram_read_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  base_addr;
  logic [9:0]  length;
  logic [8:0]  rd_addr1, rd_addr2;
  logic [47:0] rd_data1, rd_data2;
  logic [47:0] out_data;
  logic        out_valid, out_ready, busy, done;

  logic [47:0] sram [512];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  vsram_read_seq dut (
    .clock(clock), .reset(reset), .start(start),
    .base_addr(base_addr), .length(length),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  assign rd_data1 = sram[rd_addr1];
  assign rd_data2 = sram[rd_addr2];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: records accepted words, done pulses and stability violations.
  logic [47:0] got_q [$];
  int          xcyc_q [$];
  int          vrise_q [$];
  int          done_cnt = 0, done_cyc = 0, vld_seen = 0, busy_seen = 0, stab_err = 0;
  logic        prev_hold = 1'b0, prev_vld = 1'b0;
  logic [47:0] prev_data = 48'd0;

  always @(negedge clock) begin
    if (reset) begin
      prev_hold <= 1'b0;
      prev_vld  <= 1'b0;
    end else begin
      if (prev_hold && (!out_valid || out_data !== prev_data)) stab_err <= stab_err + 1;
      if (out_valid && !prev_vld) vrise_q.push_back(cyc);
      if (out_valid) vld_seen <= vld_seen + 1;
      if (busy) busy_seen <= busy_seen + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        xcyc_q.push_back(cyc);
      end
      prev_hold <= out_valid && !out_ready;
      prev_vld  <= out_valid;
      prev_data <= out_data;
    end
  end

  // mode 0: ready high; 1: random ready; 2: ready low 10 cycles then high
  task automatic drive_burst(input logic [8:0] b, input logic [9:0] len, input int mode,
                             input bit dup, output int sc, output bit tmo,
                             output logic [8:0] stall_addr);
    int d0;
    d0 = done_cnt;
    stall_addr = 9'd0;
    @(posedge clock); #1;
    start = 1'b1; base_addr = b; length = len; out_ready = (mode == 0);
    @(posedge clock); #1;
    start = 1'b0; sc = cyc;
    base_addr = 9'($urandom); length = 10'($urandom_range(1, 512));
    tmo = 1'b1;
    for (int k = 0; k < 4 * int'(len) + 60; k++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (k >= 10);
      endcase
      start = dup && (k == 3);
      if (k == 9) stall_addr = rd_addr1;
      @(posedge clock); #1;
      if (done_cnt != d0) begin
        tmo = 1'b0;
        break;
      end
    end
    start = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; base_addr = 9'd0; length = 10'd0; out_ready = 1'b0;
    #1;
    n_tests++;
    if ({rd_addr1, rd_addr2} !== 18'd0) begin
      n_fail++; $display("FAIL reset_addr got=%h/%h want=0/0", rd_addr1, rd_addr2);
    end
    n_tests++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctl got v/b/d=%b%b%b want=000", out_valid, busy, done);
    end
    n_tests++;
    if (out_data !== 48'd0) begin
      n_fail++; $display("FAIL reset_data got=%h want=0", out_data);
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic check_stream(input string nm, input logic [8:0] b, input logic [9:0] len,
                              input int g0, input int d0, input int s0, input bit tmo);
    int errs;
    n_tests++;
    if (tmo) begin
      n_fail++; $display("FAIL %s_timeout got=no done want=done", nm);
    end
    n_tests++;
    if (got_q.size() - g0 != int'(len)) begin
      n_fail++; $display("FAIL %s_count got=%0d want=%0d", nm, got_q.size() - g0, len);
    end
    errs = 0;
    for (int i = 0; i < int'(len); i++)
      if (g0 + i >= got_q.size() || got_q[g0 + i] !== sram[(int'(b) + i) % 512]) errs++;
    n_tests++;
    if (errs != 0) begin
      n_fail++; $display("FAIL %s_data got=%0d bad words want=0", nm, errs);
    end
    n_tests++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL %s_done got=%0d pulses want=1", nm, done_cnt - d0);
    end
    n_tests++;
    if (stab_err != s0) begin
      n_fail++; $display("FAIL %s_stable got=%0d violations want=0", nm, stab_err - s0);
    end
  endtask

  task automatic test_basic;
    int sc, g0, d0, s0, r0; bit tmo; logic [8:0] sa;
    g0 = got_q.size(); d0 = done_cnt; s0 = stab_err; r0 = vrise_q.size();
    drive_burst(9'h010, 10'd4, 0, 1'b0, sc, tmo, sa);
    check_stream("basic", 9'h010, 10'd4, g0, d0, s0, tmo);
    n_tests++;
    if (vrise_q.size() <= r0 || vrise_q[r0] != sc + 2) begin
      n_fail++; $display("FAIL basic_latency got=%0d want=%0d", vrise_q.size() > r0 ? vrise_q[r0] - sc : -1, 2);
    end
    n_tests++;
    if (xcyc_q.size() < g0 + 4 || done_cyc != xcyc_q[g0 + 3] + 1) begin
      n_fail++; $display("FAIL basic_done_time got=%0d want=last_xfer+1", done_cyc);
    end
  endtask

  task automatic test_wrap;
    int sc, g0, d0, s0; bit tmo; logic [8:0] sa;
    g0 = got_q.size(); d0 = done_cnt; s0 = stab_err;
    drive_burst(9'h1FE, 10'd5, 1, 1'b0, sc, tmo, sa);
    check_stream("wrap", 9'h1FE, 10'd5, g0, d0, s0, tmo);
  endtask

  task automatic test_backpressure;
    int sc, g0, d0, s0; bit tmo; logic [8:0] sa, b;
    b = 9'($urandom);
    g0 = got_q.size(); d0 = done_cnt; s0 = stab_err;
    drive_burst(b, 10'd8, 2, 1'b0, sc, tmo, sa);
    check_stream("bp", b, 10'd8, g0, d0, s0, tmo);
    n_tests++;
    if (sa !== b + 9'd2) begin
      n_fail++; $display("FAIL bp_stall_addr got=%h want=%h", sa, b + 9'd2);
    end
  endtask

  task automatic test_zero_len;
    int sc, g0, d0, v0, b0; bit tmo; logic [8:0] sa;
    g0 = got_q.size(); d0 = done_cnt; v0 = vld_seen; b0 = busy_seen;
    drive_burst(9'($urandom), 10'd0, 0, 1'b0, sc, tmo, sa);
    n_tests++;
    if (tmo || done_cnt - d0 != 1 || done_cyc != sc) begin
      n_fail++; $display("FAIL zero_done got=%0d pulses at +%0d want=1 at +0", done_cnt - d0, done_cyc - sc);
    end
    n_tests++;
    if (vld_seen != v0 || got_q.size() != g0) begin
      n_fail++; $display("FAIL zero_valid got=%0d valid cycles want=0", vld_seen - v0);
    end
    n_tests++;
    if (busy_seen != b0) begin
      n_fail++; $display("FAIL zero_busy got=%0d busy cycles want=0", busy_seen - b0);
    end
  endtask

  task automatic test_dup_start;
    int sc, g0, d0, s0; bit tmo; logic [8:0] sa, b;
    b = 9'($urandom);
    g0 = got_q.size(); d0 = done_cnt; s0 = stab_err;
    drive_burst(b, 10'd12, 1, 1'b1, sc, tmo, sa);
    check_stream("dup", b, 10'd12, g0, d0, s0, tmo);
  endtask

  task automatic test_back_to_back;
    int sc, g0, d0, s0, errs; bit tmo; logic [8:0] sa, b;
    b = 9'($urandom);
    g0 = got_q.size(); d0 = done_cnt; s0 = stab_err;
    drive_burst(b, 10'd20, 0, 1'b0, sc, tmo, sa);
    check_stream("b2b", b, 10'd20, g0, d0, s0, tmo);
    errs = 0;
    for (int i = g0 + 1; i < xcyc_q.size(); i++)
      if (xcyc_q[i] != xcyc_q[i - 1] + 1) errs++;
    n_tests++;
    if (errs != 0) begin
      n_fail++; $display("FAIL b2b_rate got=%0d gaps want=0", errs);
    end
  endtask

  task automatic test_random;
    int sc, g0, d0, s0; bit tmo; logic [8:0] sa, b; logic [9:0] len;
    for (int t = 0; t < 7; t++) begin
      b   = 9'($urandom);
      len = (t == 6) ? 10'd512 : 10'($urandom_range(1, 40));
      g0 = got_q.size(); d0 = done_cnt; s0 = stab_err;
      drive_burst(b, len, 1, 1'b0, sc, tmo, sa);
      check_stream("rand", b, len, g0, d0, s0, tmo);
    end
  endtask

  task automatic test_reset_mid;
    int sc, g0, d0, s0; bit tmo; logic [8:0] sa;
    g0 = got_q.size(); d0 = done_cnt; s0 = stab_err;
    @(posedge clock); #1;
    start = 1'b1; base_addr = 9'($urandom_range(1, 500)); length = 10'd16; out_ready = 1'b0;
    @(posedge clock); #1 start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({rd_addr1, rd_addr2, out_valid, out_data, busy, done} !== 69'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got a1=%h a2=%h v=%b d=%h b=%b dn=%b want=all 0",
               rd_addr1, rd_addr2, out_valid, out_data, busy, done);
    end
    @(posedge clock); #1 reset = 1'b0;
    drive_burst(9'h020, 10'd2, 0, 1'b0, sc, tmo, sa);
    check_stream("rstmid", 9'h020, 10'd2, g0, d0, s0, tmo);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      sram[i] = t[47:0];
    end
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_zero_len;
    test_dup_start;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
